alu_mul_seq: RTL and testbench
==============================

// Module: alu_mul_seq
// PURPOSE
// - Multi-cycle unsigned 8x8->16 shift-and-add multiplier sequencer. It owns no adder; every add borrows the shared 8-bit ALU.
// - Sits beside the execute stage. It raises alu_req and drives the ALU operand/function muxes only in cycles where alu_gnt=1.
// - The execute stage always has priority; alu_gnt=1 means the ALU is free this cycle.
// - Stalls the pipeline through stall_o while a multiply is in flight.
// PARAMETERS
// - WIDTH   8        operand width; fixed to the ALU width, only 8 supported
// - CNT_W   3        iteration counter width, $clog2(WIDTH)
// - FUN_ADD 4'b0000  ALU function code for ADD
// PORTS
// - clk       in   1   rising-edge clock
// - reset     in   1   reset, synchronous, active-low
// - start     in   1   request a multiply; sampled only in IDLE
// - op_a      in   8   multiplicand, captured on accepted start
// - op_b      in   8   multiplier, captured on accepted start
// - alu_gnt   in   1   ALU free for this block this cycle
// - alu_out_i in   8   ALU result (combinational, same cycle)
// - alu_req   out  1   block needs the ALU this cycle
// - alu_fun_o out  4   ALU function: FUN_ADD when alu_req, else 4'b0000
// - alu_a_o   out  8   ALU operand a: acc_hi when alu_req, else 0
// - alu_b_o   out  8   ALU operand b: multiplicand when alu_req, else 0
// - busy      out  1   high in RUN
// - stall_o   out  1   equals busy
// - done      out  1   one-cycle pulse, product valid
// - product   out  16  result; held from DONE until the next accepted start
// - prod_zero out  1   product==0; updated together with product
// BEHAVIOUR
// - Reset (reset=0 at posedge): state=IDLE, counter=0, internal regs=0, product=0, prod_zero=0, done=0.
//   Reset mid-operation aborts immediately; the partial result is discarded.
// - States: IDLE -> RUN -> DONE -> IDLE.
// - IDLE, start=1: load mcand=op_a, acc_hi=0, acc_lo=op_b, cnt=0; go to RUN. start=0: stay.
// - RUN, one iteration per advancing cycle:
//   - acc_lo[0]=0: {acc_hi,acc_lo} >>= 1 with 0 shifted in; cnt++. alu_req=0; the ALU is not used.
//   - acc_lo[0]=1: alu_req=1.
//     - alu_gnt=1: sum=alu_out_i; c computed locally (below); {acc_hi,acc_lo} <= {c,sum,acc_lo[7:1]}; cnt++.
//     - alu_gnt=0: hold all registers and cnt. Stall is unbounded; no timeout.
//   - The iteration that completes with cnt==7 moves to DONE.
// - Carry: c = (a7&b7)|((a7|b7)&~sum7), where a7/b7 are the MSBs of the operands driven to the ALU.
//   The ALU cout is signed-extended and is NOT used.
// - DONE: done=1; product <= {acc_hi,acc_lo}, registered on entry so product is valid in the same cycle as done.
//   prod_zero valid with it. Next state IDLE unconditionally.
// - start in RUN or DONE is ignored (no queue). start in IDLE the cycle after DONE is accepted.
// - Latency with alu_gnt=1 throughout: start sampled at edge N, done high in cycle N+9.
//   Each withheld grant on a '1' bit adds one cycle.
// - op_a/op_b changes after capture have no effect.
// - alu_* outputs are combinational from state/regs and never depend on alu_gnt (no comb loop through the arbiter).
// STRUCTURE
// - Shared package: FUN_* ALU function codes (ADD/SUB/AND/OR/UNARY/CARRY), state encoding typedef, WIDTH constant.
//   The ALU decoder and this block use the same codes.
// - Single module; no sub-module. Arbitration stays in the execute stage, which drives alu_gnt.
// TESTING
// - 13*11, gnt=1 always -> product=16'h008F, done pulse at start+9, stall_o high cycles 1-8.
// - 255*255 -> 16'hFE01. Exercises the local carry on every add; a bench must flag any use of ALU cout.
// - 8'hA5*0 -> product=0, prod_zero=1, alu_req never asserted.
// - 15*3, alu_gnt=0 for 5 cycles on first add -> registers/cnt frozen, alu_req held, product=16'h002D, done at start+14.
// - reset=0 after 4 iterations of 200*100 -> next cycle busy=0, product=0. Then 2*3 -> product=6.
// - start pulsed during RUN and DONE -> ignored. start in the cycle after done -> new op accepted, prior product held until then.

Source files
------------

// File: rtl/alu_mul_seq_pkg.sv
// Shared definitions for the sequential multiplier and the ALU decoder.
package alu_mul_seq_pkg;

    // Operand width is tied to the shared ALU; only 8 is supported.
    localparam int unsigned WIDTH = 8;
    // Iteration counter width, $clog2(WIDTH).
    localparam int unsigned CNT_W = 3;
    // Product width.
    localparam int unsigned PROD_W = 2 * WIDTH;

    // ALU function codes, common to the ALU decoder and its requesters.
    localparam logic [3:0] FUN_ADD   = 4'b0000;
    localparam logic [3:0] FUN_SUB   = 4'b0001;
    localparam logic [3:0] FUN_AND   = 4'b0010;
    localparam logic [3:0] FUN_OR    = 4'b0011;
    localparam logic [3:0] FUN_UNARY = 4'b0100;
    localparam logic [3:0] FUN_CARRY = 4'b0101;

    // Sequencer states.
    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StRun  = 2'b01,
        StDone = 2'b10
    } state_e;

    // Unsigned carry-out of an add, rebuilt from the operand MSBs and the sum MSB.
    // The ALU's own cout is sign-extended and cannot be used for this.
    function automatic logic add_carry(input logic a7, input logic b7, input logic sum7);
        return (a7 & b7) | ((a7 | b7) & ~sum7);
    endfunction

endpackage

// File: rtl/alu_mul_seq_if.sv
// Shared-ALU borrow port: request/grant plus operand, function and result buses.
interface alu_mul_seq_if;
    import alu_mul_seq_pkg::*;

    logic             alu_req;
    logic             alu_gnt;
    logic [3:0]       alu_fun_o;
    logic [WIDTH-1:0] alu_a_o;
    logic [WIDTH-1:0] alu_b_o;
    logic [WIDTH-1:0] alu_out_i;

    // Requester side (the multiplier).
    modport master (
        output alu_req,
        output alu_fun_o,
        output alu_a_o,
        output alu_b_o,
        input  alu_gnt,
        input  alu_out_i
    );

    // Execute-stage side: arbitrates and returns the ALU result.
    modport slave (
        input  alu_req,
        input  alu_fun_o,
        input  alu_a_o,
        input  alu_b_o,
        output alu_gnt,
        output alu_out_i
    );

endinterface

// File: rtl/alu_mul_seq.sv
// Unsigned 8x8->16 shift-and-add multiplier that borrows the shared ALU for every add.
module alu_mul_seq
    import alu_mul_seq_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [WIDTH-1:0]    op_a,
    input  logic [WIDTH-1:0]    op_b,
    alu_mul_seq_if.master       alu_bus,
    output logic                busy,
    output logic                stall_o,
    output logic                done,
    output logic [PROD_W-1:0]   product,
    output logic                prod_zero
);

    localparam logic [CNT_W-1:0] LastIter = CNT_W'(WIDTH - 1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0]   acc_hi_q, acc_hi_d;
    logic [WIDTH-1:0]   acc_lo_q, acc_lo_d;
    logic [PROD_W-1:0]  product_q, product_d;
    logic               prod_zero_q, prod_zero_d;

    // An add is pending whenever the current multiplier bit is 1.
    logic add_bit;
    // The current iteration completes this cycle.
    logic advance;
    logic add_cout;

    assign add_bit  = acc_lo_q[0];
    assign advance  = (state_q == StRun) && (!add_bit || alu_bus.alu_gnt);
    assign add_cout = add_carry(acc_hi_q[WIDTH-1], mcand_q[WIDTH-1], alu_bus.alu_out_i[WIDTH-1]);

    // State register, synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                if (advance && (cnt_q == LastIter)) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Datapath registers; reset aborts any multiply in flight.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q       <= '0;
            mcand_q     <= '0;
            acc_hi_q    <= '0;
            acc_lo_q    <= '0;
            product_q   <= '0;
            prod_zero_q <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            mcand_q     <= mcand_d;
            acc_hi_q    <= acc_hi_d;
            acc_lo_q    <= acc_lo_d;
            product_q   <= product_d;
            prod_zero_q <= prod_zero_d;
        end
    end

    // Datapath next-state: operand capture, shift/add iterations, product capture.
    always_comb begin
        cnt_d       = cnt_q;
        mcand_d     = mcand_q;
        acc_hi_d    = acc_hi_q;
        acc_lo_d    = acc_lo_q;
        product_d   = product_q;
        prod_zero_d = prod_zero_q;

        if ((state_q == StIdle) && start) begin
            mcand_d  = op_a;
            acc_hi_d = '0;
            acc_lo_d = op_b;
            cnt_d    = '0;
        end

        if (advance) begin
            if (add_bit) begin
                {acc_hi_d, acc_lo_d} = {add_cout, alu_bus.alu_out_i, acc_lo_q[WIDTH-1:1]};
            end else begin
                {acc_hi_d, acc_lo_d} = {1'b0, acc_hi_q, acc_lo_q[WIDTH-1:1]};
            end
            cnt_d = cnt_q + CNT_W'(1);
        end

        // Product is registered on the way into DONE so it is valid alongside done.
        if ((state_q == StRun) && (state_d == StDone)) begin
            product_d   = {acc_hi_d, acc_lo_d};
            prod_zero_d = ({acc_hi_d, acc_lo_d} == '0);
        end
    end

    // Outputs; the ALU bus depends only on state and registers, never on alu_gnt.
    always_comb begin
        alu_bus.alu_req   = 1'b0;
        alu_bus.alu_fun_o = 4'b0000;
        alu_bus.alu_a_o   = '0;
        alu_bus.alu_b_o   = '0;
        busy              = 1'b0;
        done              = 1'b0;

        unique case (state_q)
            StRun: begin
                busy = 1'b1;
                if (add_bit) begin
                    alu_bus.alu_req   = 1'b1;
                    alu_bus.alu_fun_o = FUN_ADD;
                    alu_bus.alu_a_o   = acc_hi_q;
                    alu_bus.alu_b_o   = mcand_q;
                end
            end
            StDone: begin
                done = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign stall_o   = busy;
    assign product   = product_q;
    assign prod_zero = prod_zero_q;

endmodule

// File: tb/tb_alu_mul_seq.sv
// Scoreboard bench for alu_mul_seq: the bench plays the execute stage and the ALU.
module tb_alu_mul_seq;
    import alu_mul_seq_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [7:0]  op_a;
    logic [7:0]  op_b;
    logic        busy;
    logic        stall_o;
    logic        done;
    logic [15:0] product;
    logic        prod_zero;

    alu_mul_seq_if alu_if();

    alu_mul_seq dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .op_a      (op_a),
        .op_b      (op_b),
        .alu_bus   (alu_if),
        .busy      (busy),
        .stall_o   (stall_o),
        .done      (done),
        .product   (product),
        .prod_zero (prod_zero)
    );

    always #5 clk = ~clk;

    // Plain 8-bit ALU adder; its carry-out is deliberately not exposed.
    assign alu_if.alu_out_i = alu_if.alu_a_o + alu_if.alu_b_o;

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] prod;
        logic        zero;
        int unsigned ones;
    } exp_t;

    exp_t exp_q[$];

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    // Bench-side view of the transaction protocol.
    bit in_flight    = 1'b0;
    bit release_pend = 1'b0;
    bit rand_gnt     = 1'b0;
    int stall_budget = 0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), required %0d (0x%0h) at %0t",
                     name, act, act, req, req, $time);
        end
    endfunction

    function automatic logic [7:0] rand_byte();
        case ($urandom_range(0, 7))
            0:       return 8'h00;
            1:       return 8'hFF;
            default: return 8'($urandom);
        endcase
    endfunction

    // One clock: record an accepted start, retire a finished op, then drive the grant.
    task automatic tick();
        exp_t e;
        @(posedge clk);
        if (reset && start && !in_flight) begin
            e.a    = op_a;
            e.b    = op_b;
            e.prod = 16'(op_a) * 16'(op_b);
            e.zero = (e.prod == 16'h0000);
            e.ones = $countones(op_b);
            exp_q.push_back(e);
            in_flight = 1'b1;
        end else if (release_pend) begin
            in_flight    = 1'b0;
            release_pend = 1'b0;
        end
        #1;
        if (stall_budget > 0 && alu_if.alu_req) begin
            alu_if.alu_gnt = 1'b0;
            stall_budget--;
        end else if (rand_gnt) begin
            alu_if.alu_gnt = ($urandom_range(0, 3) != 0);
        end else begin
            alu_if.alu_gnt = 1'b1;
        end
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (in_flight && n < 400) begin
            tick();
            n++;
        end
        if (in_flight) begin
            chk({name, "_timeout"}, 32'(in_flight), 32'd0);
            in_flight = 1'b0;
            release_pend = 1'b0;
            exp_q.delete();
        end
    endtask

    task automatic do_op(input logic [7:0] a, input logic [7:0] b, input int stall);
        int n = 0;
        op_a = a;
        op_b = b;
        stall_budget = stall;
        start = 1'b1;
        while (!in_flight && n < 20) begin
            tick();
            n++;
        end
        start = 1'b0;
        chk("op_accepted", 32'(in_flight), 32'd1);
        // Operand changes after capture must not matter.
        op_a = ~a;
        op_b = ~b;
        drain("op_done");
    endtask

    // Monitor: counts cycles/grants per op and compares at each done pulse.
    int unsigned cyc, stalls, adds, busy_cyc;
    bit          bus_err, hold_err, stall_err;
    logic [15:0] last_prod = 16'h0000;

    always @(negedge clk) begin
        exp_t e;
        if (!reset) begin
            cyc = 0; stalls = 0; adds = 0; busy_cyc = 0;
            bus_err = 0; hold_err = 0; stall_err = 0;
            last_prod = 16'h0000;
        end else begin
            if (stall_o !== busy) stall_err = 1;
            if (!alu_if.alu_req && (alu_if.alu_fun_o != 4'b0000 || alu_if.alu_a_o != 8'h00 ||
                                    alu_if.alu_b_o != 8'h00)) bus_err = 1;
            if (!busy && !done && product !== last_prod) hold_err = 1;
            if (exp_q.size() > 0) begin
                cyc++;
                if (busy) busy_cyc++;
                if (alu_if.alu_req) begin
                    if (alu_if.alu_gnt) adds++;
                    else stalls++;
                    if (alu_if.alu_fun_o !== FUN_ADD || alu_if.alu_b_o !== exp_q[0].a) bus_err = 1;
                end
                if (done) begin
                    e = exp_q.pop_front();
                    chk("product", 32'(product), 32'(e.prod));
                    chk("prod_zero", 32'(prod_zero), 32'(e.zero));
                    chk("latency", cyc, 9 + stalls);
                    chk("busy_cycles", busy_cyc, 8 + stalls);
                    chk("alu_adds", adds, e.ones);
                    chk("alu_bus_ok", 32'(bus_err), 32'd0);
                    chk("product_held", 32'(hold_err), 32'd0);
                    chk("stall_eq_busy", 32'(stall_err), 32'd0);
                    last_prod = e.prod;
                    cyc = 0; stalls = 0; adds = 0; busy_cyc = 0;
                    bus_err = 0; hold_err = 0; stall_err = 0;
                    release_pend = 1'b1;
                end
            end else if (done) begin
                chk("unexpected_done", 32'(done), 32'd0);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got running, required finished");
        $fatal(1);
    end

    initial begin
        reset = 1'b0;
        start = 1'b0;
        op_a  = 8'h00;
        op_b  = 8'h00;
        alu_if.alu_gnt = 1'b1;
        repeat (3) tick();
        @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_product", 32'(product), 32'd0);
        chk("rst_prod_zero", 32'(prod_zero), 32'd0);
        chk("rst_alu_req", 32'(alu_if.alu_req), 32'd0);
        reset = 1'b1;
        tick();

        // Directed cases.
        do_op(8'd13, 8'd11, 0);
        do_op(8'd255, 8'd255, 0);
        do_op(8'hA5, 8'h00, 0);
        do_op(8'd15, 8'd3, 5);
        do_op(8'd0, 8'd77, 0);

        // Reset after four iterations of 200*100 aborts the multiply.
        op_a = 8'd200;
        op_b = 8'd100;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("abort_accepted", 32'(in_flight), 32'd1);
        repeat (4) tick();
        reset = 1'b0;
        exp_q.delete();
        in_flight = 1'b0;
        release_pend = 1'b0;
        tick();
        @(negedge clk);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_product", 32'(product), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_prod_zero", 32'(prod_zero), 32'd0);
        reset = 1'b1;
        tick();
        do_op(8'd2, 8'd3, 0);

        // Start held high: ignored in RUN/DONE, accepted in the IDLE after DONE.
        start = 1'b1;
        for (int i = 0; i < 60; i++) begin
            op_a = rand_byte();
            op_b = rand_byte();
            tick();
        end
        start = 1'b0;
        drain("b2b");

        // Randomised starts, operands and grants.
        rand_gnt = 1'b1;
        for (int i = 0; i < 500; i++) begin
            start = ($urandom_range(0, 2) == 0);
            op_a  = rand_byte();
            op_b  = rand_byte();
            tick();
        end
        start = 1'b0;
        drain("random");
        rand_gnt = 1'b0;
        repeat (3) tick();
        chk("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
